// File: rtl/video_bus.sv
// rtl/video_bus.sv - video_bus interface: pixel clock, syncs, blank/border flags and 32-bit pixel data.
interface video_bus;
   logic        clk;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic        border;
   logic [31:0] data;

   modport out (output clk, hsync, vsync, blank, border, data);
   modport in  (input  clk, hsync, vsync, blank, border, data);
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - video timing generator and pixel serializer driving video_bus.out.
// Optional colour-bar test pattern (tpg_i, BARW) under `VIDEO_TIMING_GEN_TPG_EN.
module video_timing_gen #(
   parameter int HACT  = 640,
   parameter int HFP   = 16,
   parameter int HSW   = 96,
   parameter int HBP   = 48,
   parameter int VACT  = 480,
   parameter int VFP   = 10,
   parameter int VSW   = 2,
   parameter int VBP   = 33,
   parameter int HBRD  = 0,
   parameter int VBRD  = 0,
   parameter bit HSPOL = 1'b1,
`ifdef VIDEO_TIMING_GEN_TPG_EN
   parameter bit VSPOL = 1'b1,
   parameter int BARW  = 80
`else
   parameter bit VSPOL = 1'b1
`endif
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] border_color_i,
   input  logic        pix_valid_i,
   input  logic [31:0] pix_data_i,
`ifdef VIDEO_TIMING_GEN_TPG_EN
   input  logic        tpg_i,
`endif
   output logic        pix_ready_o,
   output logic        sof_o,
   output logic        underflow_o,
   video_bus.out       vid
);
   localparam int HTOT = HACT + HFP + HSW + HBP;
   localparam int VTOT = VACT + VFP + VSW + VBP;
   localparam int HW   = $clog2(HTOT + 1);
   localparam int VW   = $clog2(VTOT + 1);

   localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(HACT);
   localparam logic [HW-1:0] H_DE   = HW'(HACT - HBRD);
   localparam logic [HW-1:0] H_SS   = HW'(HACT + HFP);
   localparam logic [HW-1:0] H_SE   = HW'(HACT + HFP + HSW);
   localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(VACT);
   localparam logic [VW-1:0] V_DE   = VW'(VACT - VBRD);
   localparam logic [VW-1:0] V_SS   = VW'(VACT + VFP);
   localparam logic [VW-1:0] V_SE   = VW'(VACT + VFP + VSW);

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic          r_hsync, r_vsync, r_blank, r_border, r_sof, r_underflow;
   logic [31:0]   r_data;

   logic          w_hdisp, w_vdisp, w_active, w_display, w_frame_start, w_tpg, w_underflow;
   logic [31:0]   w_data;
   logic [31:0]   w_bar_color;

   // A zero-width border makes the lower bound vacuous, so it is left out entirely.
   generate
      if (HBRD == 0) begin : g_hdisp_full
         assign w_hdisp = r_hcnt < H_DE;
      end else begin : g_hdisp_brd
         assign w_hdisp = (r_hcnt >= HW'(HBRD)) && (r_hcnt < H_DE);
      end
      if (VBRD == 0) begin : g_vdisp_full
         assign w_vdisp = r_vcnt < V_DE;
      end else begin : g_vdisp_brd
         assign w_vdisp = (r_vcnt >= VW'(VBRD)) && (r_vcnt < V_DE);
      end
   endgenerate

   assign w_active      = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
   assign w_display     = w_hdisp && w_vdisp;
   assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_underflow   = w_display && !w_tpg && !pix_valid_i;
   assign pix_ready_o   = en_i && !rst_i && w_display && !w_tpg;

`ifdef VIDEO_TIMING_GEN_TPG_EN
   localparam int BW = $clog2(BARW + 1);
   logic [BW-1:0] r_bar_px;
   logic [2:0]    r_bar_idx;

   assign w_tpg = tpg_i;

   // Bar position restarts whenever the display window is left, so each line begins at bar 0.
   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i || !w_display) begin
         r_bar_px  <= '0;
         r_bar_idx <= '0;
      end else if (r_bar_px == BW'(BARW - 1)) begin
         r_bar_px  <= '0;
         r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
         r_bar_px  <= r_bar_px + 1'b1;
      end
   end

   always_comb begin
      w_bar_color = 32'h0000_0000;
      case (r_bar_idx)
         3'd0: w_bar_color = 32'h00FF_FFFF;
         3'd1: w_bar_color = 32'h00FF_FF00;
         3'd2: w_bar_color = 32'h0000_FFFF;
         3'd3: w_bar_color = 32'h0000_FF00;
         3'd4: w_bar_color = 32'h00FF_00FF;
         3'd5: w_bar_color = 32'h00FF_0000;
         3'd6: w_bar_color = 32'h0000_00FF;
         3'd7: w_bar_color = 32'h0000_0000;
         default: w_bar_color = 32'h0000_0000;
      endcase
   end
`else
   assign w_tpg       = 1'b0;
   assign w_bar_color = 32'h0000_0000;
`endif

   always_comb begin
      w_data = 32'h0000_0000;
      if (w_display) begin
         if (w_tpg)
            w_data = w_bar_color;
         else if (pix_valid_i)
            w_data = pix_data_i;
      end else if (w_active) begin
         w_data = border_color_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         r_hcnt      <= '0;
         r_vcnt      <= '0;
         r_hsync     <= ~HSPOL;
         r_vsync     <= ~VSPOL;
         r_blank     <= 1'b1;
         r_border    <= 1'b0;
         r_data      <= 32'h0000_0000;
         r_sof       <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
         end else begin
            r_hcnt <= r_hcnt + 1'b1;
         end
         r_hsync     <= ((r_hcnt >= H_SS) && (r_hcnt < H_SE)) ? HSPOL : ~HSPOL;
         r_vsync     <= ((r_vcnt >= V_SS) && (r_vcnt < V_SE)) ? VSPOL : ~VSPOL;
         r_blank     <= !w_active;
         r_border    <= w_active && !w_display;
         r_data      <= w_data;
         r_sof       <= w_frame_start;
         // New-frame clear loses to an underflow on the very same pixel.
         r_underflow <= (r_underflow && !w_frame_start) || w_underflow;
      end
   end

   assign vid.clk    = clk_i;
   assign vid.hsync  = r_hsync;
   assign vid.vsync  = r_vsync;
   assign vid.blank  = r_blank;
   assign vid.border = r_border;
   assign vid.data   = r_data;
   assign sof_o       = r_sof;
   assign underflow_o = r_underflow;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen with a 16x8 pixel raster.
module tb_video_timing_gen;
   localparam int N = 128;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        en_i;
   logic [31:0] border_color_i;
   logic        pix_valid_i;
   logic [31:0] pix_data_i;
   logic        tpg_i;
   logic        pix_ready_o;
   logic        sof_o;
   logic        underflow_o;

   video_bus vb ();

   video_timing_gen #(
      .HACT(8), .HFP(2), .HSW(3), .HBP(3),
      .VACT(4), .VFP(1), .VSW(2), .VBP(1),
      .HBRD(1), .VBRD(1), .HSPOL(1'b1),
`ifdef VIDEO_TIMING_GEN_TPG_EN
      .VSPOL(1'b1), .BARW(2)
`else
      .VSPOL(1'b1)
`endif
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .border_color_i (border_color_i),
      .pix_valid_i    (pix_valid_i),
      .pix_data_i     (pix_data_i),
`ifdef VIDEO_TIMING_GEN_TPG_EN
      .tpg_i          (tpg_i),
`endif
      .pix_ready_o    (pix_ready_o),
      .sof_o          (sof_o),
      .underflow_o    (underflow_o),
      .vid            (vb)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          pos;
      logic        hs;
      logic        vs;
      logic        bl;
      logic        bd;
      logic [31:0] data;
   } vec_t;

   vec_t        vecs[18];
   logic        cap_hs[N], cap_vs[N], cap_bl[N], cap_bd[N];
   logic        cap_sof[N], cap_uf[N], cap_rdy[N];
   logic [31:0] cap_data[N];
   int          p;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives one pixel slot at raster position p and records the outputs it produces.
   task automatic tick(input logic valid);
      int q;
      q = p;
      pix_valid_i = valid;
      pix_data_i  = 32'hD000_0000 | q;
      #1;
      cap_rdy[q] = pix_ready_o;
      @(posedge clk);
      p = (p + 1) % N;
      @(negedge clk);
      cap_hs[q]   = vb.hsync;
      cap_vs[q]   = vb.vsync;
      cap_bl[q]   = vb.blank;
      cap_bd[q]   = vb.border;
      cap_data[q] = vb.data;
      cap_sof[q]  = sof_o;
      cap_uf[q]   = underflow_o;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_hsync"},  {31'd0, vb.hsync},  32'd0);
      chk({tag, "_vsync"},  {31'd0, vb.vsync},  32'd0);
      chk({tag, "_blank"},  {31'd0, vb.blank},  32'd1);
      chk({tag, "_border"}, {31'd0, vb.border}, 32'd0);
      chk({tag, "_data"},   vb.data,            32'd0);
      chk({tag, "_sof"},    {31'd0, sof_o},     32'd0);
   endtask

   initial begin
      int cnt_hs, cnt_vs, cnt_sof, cnt_rdy, bad_lines;

      // pos = line*16 + pixel; hsync at pixels 10..12, vsync on lines 5..6
      vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555};
      vecs[1]  = '{16,  1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555};
      vecs[2]  = '{17,  1'b0, 1'b0, 1'b0, 1'b0, 32'hD0000011};
      vecs[3]  = '{22,  1'b0, 1'b0, 1'b0, 1'b0, 32'hD0000016};
      vecs[4]  = '{23,  1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555};
      vecs[5]  = '{24,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[6]  = '{26,  1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[7]  = '{28,  1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[8]  = '{29,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[9]  = '{9,   1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[10] = '{38,  1'b0, 1'b0, 1'b0, 1'b0, 32'hD0000026};
      vecs[11] = '{51,  1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555};
      vecs[12] = '{64,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[13] = '{79,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000};
      vecs[14] = '{80,  1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000};
      vecs[15] = '{90,  1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000};
      vecs[16] = '{111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000};
      vecs[17] = '{112, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000};

      rst_i          = 1'b1;
      en_i           = 1'b1;
      border_color_i = 32'hAAAA5555;
      pix_valid_i    = 1'b0;
      pix_data_i     = 32'd0;
      tpg_i          = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset_underflow", {31'd0, underflow_o}, 32'd0);
      chk("reset_ready",     {31'd0, pix_ready_o}, 32'd0);

      // Frame A: free-running, every pixel supplied
      rst_i = 1'b0;
      p = 0;
      for (int q = 0; q < N; q++) tick(1'b1);

      for (int i = 0; i < 18; i++) begin
         chk($sformatf("vec%0d_hsync",  vecs[i].pos), {31'd0, cap_hs[vecs[i].pos]}, {31'd0, vecs[i].hs});
         chk($sformatf("vec%0d_vsync",  vecs[i].pos), {31'd0, cap_vs[vecs[i].pos]}, {31'd0, vecs[i].vs});
         chk($sformatf("vec%0d_blank",  vecs[i].pos), {31'd0, cap_bl[vecs[i].pos]}, {31'd0, vecs[i].bl});
         chk($sformatf("vec%0d_border", vecs[i].pos), {31'd0, cap_bd[vecs[i].pos]}, {31'd0, vecs[i].bd});
         chk($sformatf("vec%0d_data",   vecs[i].pos), cap_data[vecs[i].pos], vecs[i].data);
      end

      cnt_hs = 0; cnt_vs = 0; cnt_sof = 0; cnt_rdy = 0; bad_lines = 0;
      for (int q = 0; q < N; q++) begin
         cnt_hs  += int'(cap_hs[q]);
         cnt_vs  += int'(cap_vs[q]);
         cnt_sof += int'(cap_sof[q]);
         cnt_rdy += int'(cap_rdy[q]);
      end
      for (int v = 0; v < 8; v++)
         if (cap_hs[16*v+9] !== 1'b0 || cap_hs[16*v+10] !== 1'b1 || cap_hs[16*v+13] !== 1'b0)
            bad_lines++;
      chk("hsync_count",     cnt_hs,  32'd24);
      chk("vsync_count",     cnt_vs,  32'd32);
      chk("sof_count",       cnt_sof, 32'd1);
      chk("sof_at_origin",   {31'd0, cap_sof[0]}, 32'd1);
      chk("ready_count",     cnt_rdy, 32'd12);
      chk("hsync_phase_bad", bad_lines, 32'd0);
      chk("ready_at_17",     {31'd0, cap_rdy[17]}, 32'd1);
      chk("ready_at_16",     {31'd0, cap_rdy[16]}, 32'd0);

      // Frame B: one missing display pixel at line 2, pixel 1
      for (int q = 0; q < N; q++) tick(q != 33);
      chk("sof_period",      {31'd0, cap_sof[0]},  32'd1);
      chk("uf_data_zero",    cap_data[33],         32'd0);
      chk("uf_before",       {31'd0, cap_uf[32]},  32'd0);
      chk("uf_rise",         {31'd0, cap_uf[33]},  32'd1);
      chk("uf_hold",         {31'd0, cap_uf[127]}, 32'd1);
      chk("uf_next_data",    cap_data[34],         32'hD0000022);

      // Frame C: underflow clears with sof, then disable at line 2, pixel 5
      tick(1'b1);
      chk("uf_clear_sof",    {31'd0, cap_sof[0]}, 32'd1);
      chk("uf_cleared",      {31'd0, cap_uf[0]},  32'd0);
      for (int q = 1; q < 37; q++) tick(1'b1);
      en_i = 1'b0;
      #1;
      chk("dis_ready", {31'd0, pix_ready_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("dis");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("dis_hold");
      en_i = 1'b1;
      p = 0;
      tick(1'b1);
      chk("reen_sof",    {31'd0, cap_sof[0]}, 32'd1);
      chk("reen_border", cap_data[0],         32'hAAAA5555);
      tick(1'b1);
      chk("reen_sof_end", {31'd0, cap_sof[1]}, 32'd0);

      // Reset pulse at the same raster point
      for (int q = 2; q < 37; q++) tick(1'b1);
      rst_i = 1'b1;
      #1;
      chk("rst_ready", {31'd0, pix_ready_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      rst_i = 1'b0;
      p = 0;
      tick(1'b1);
      chk("rst_sof", {31'd0, cap_sof[0]}, 32'd1);

`ifdef VIDEO_TIMING_GEN_TPG_EN
      for (int q = 1; q < N; q++) tick(1'b1);
      tpg_i = 1'b1;
      cnt_rdy = 0;
      for (int q = 0; q < N; q++) begin
         tick(1'b0);
         cnt_rdy += int'(cap_rdy[q]);
      end
      chk("tpg_px1", cap_data[17], 32'h00FFFFFF);
      chk("tpg_px2", cap_data[18], 32'h00FFFFFF);
      chk("tpg_px3", cap_data[19], 32'h00FFFF00);
      chk("tpg_px4", cap_data[20], 32'h00FFFF00);
      chk("tpg_px5", cap_data[21], 32'h0000FFFF);
      chk("tpg_px6", cap_data[22], 32'h0000FFFF);
      chk("tpg_ready", cnt_rdy, 32'd0);
      chk("tpg_no_uf", {31'd0, cap_uf[127]}, 32'd0);
      tpg_i = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
